// File: rtl/gpcfg_pkg.sv
// Shared constants and address decode helper for the gpcfg register bank.
package gpcfg_pkg;

    localparam int REG_W = 32;

    // Per-register access modes, two bits each in REG_MODE.
    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;
    localparam logic [1:0] MODE_W1P = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [5:0] idx;
    } dec_t;

    // Map a 16-bit byte address onto a word index.
    // A hit needs the address to be at or above the base, word aligned,
    // and inside the bank.
    function automatic dec_t decode_addr(
        input logic [15:0]  addr,
        input logic [15:0]  base,
        input int unsigned  num_regs
    );
        logic [15:0] off;
        dec_t        d;
        off   = addr - base;
        d.hit = (addr >= base) && (off[1:0] == 2'b00) &&
                (32'(off[15:2]) < num_regs);
        d.idx = off[7:2];
        return d;
    endfunction

endpackage

// File: rtl/gpcfg_reg_slice.sv
// One 32-bit register of the gpcfg bank; behaviour fixed by the MODE parameter.
module gpcfg_reg_slice
    import gpcfg_pkg::*;
#(
    parameter logic [1:0]       MODE      = MODE_RW,
    parameter logic [REG_W-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_hit,
    input  logic [3:0]       i_byte_en,
    input  logic [REG_W-1:0] i_wdata,
    input  logic [REG_W-1:0] i_hw_val,
    input  logic [REG_W-1:0] i_hw_set,
    output logic [REG_W-1:0] o_q,
    output logic             o_wr_pulse
);

    // Pulse registers must never come out of reset asserted.
    localparam logic [REG_W-1:0] RST_EFF = (MODE == MODE_W1P) ? '0 : RESET_VAL;

    logic [REG_W-1:0] r_q;
    logic             r_wr_pulse;
    logic [REG_W-1:0] w_lane_sel;
    logic [REG_W-1:0] w_wr_bits;
    logic [REG_W-1:0] w_next;

    // Expand the byte enables into a bit mask, gated by the write hit.
    always_comb begin
        w_lane_sel = '0;
        if (i_wr_hit) begin
            w_lane_sel = {{8{i_byte_en[3]}}, {8{i_byte_en[2]}},
                          {8{i_byte_en[1]}}, {8{i_byte_en[0]}}};
        end
        w_wr_bits = i_wdata & w_lane_sel;
    end

    // Next-state per access mode.
    always_comb begin
        w_next = r_q;
        case (MODE)
            MODE_RW:  w_next = (r_q & ~w_lane_sel) | w_wr_bits;
            MODE_RO:  w_next = r_q;
            // Hardware set is OR-ed in after the clear so a same-cycle set wins.
            MODE_W1C: w_next = (r_q & ~w_wr_bits) | i_hw_set;
            // Only lives for the cycle after the write; back-to-back writes keep it high.
            MODE_W1P: w_next = w_wr_bits;
            default:  w_next = r_q;
        endcase
    end

    // Register state update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_EFF;
        end else begin
            r_q <= w_next;
        end
    end

    // Write strobe fires for any accepted write with at least one lane, in every mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_pulse <= 1'b0;
        end else begin
            r_wr_pulse <= i_wr_hit && (|i_byte_en);
        end
    end

    // Read-only registers reflect the live hardware value, not stored state.
    assign o_q        = (MODE == MODE_RO) ? i_hw_val : r_q;
    assign o_wr_pulse = r_wr_pulse;

endmodule

// File: rtl/gpcfg_reg_bank.sv
// Parametrised bank of 32-bit config/status registers with registered reads and irq.
module gpcfg_reg_bank
    import gpcfg_pkg::*;
#(
    parameter int unsigned                  NUM_REGS  = 8,
    parameter logic [15:0]                  BASE_ADDR = 16'h0000,
    parameter logic [2*NUM_REGS-1:0]        REG_MODE  = {NUM_REGS{2'b00}},
    parameter logic [REG_W*NUM_REGS-1:0]    RESET_VAL = {NUM_REGS{32'h0}},
    parameter logic [REG_W*NUM_REGS-1:0]    IRQ_MASK  = {NUM_REGS{32'h0}}
) (
    input  logic                        hclk,
    input  logic                        hresetn,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [3:0]                  byte_en,
    input  logic [31:0]                 wr_addr,
    input  logic [31:0]                 rd_addr,
    input  logic [31:0]                 wdata,
    input  logic [REG_W*NUM_REGS-1:0]   hw_val,
    input  logic [REG_W*NUM_REGS-1:0]   hw_set,
    output logic [REG_W*NUM_REGS-1:0]   cfg_regs,
    output logic [NUM_REGS-1:0]         wr_pulse,
    output logic [31:0]                 rdata,
    output logic                        rd_valid,
    output logic                        irq
);

    dec_t                w_wr_dec;
    dec_t                w_rd_dec;
    logic [REG_W-1:0]    w_cfg [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_irq_src;
    logic [REG_W-1:0]    w_rd_word;
    logic [31:0]         r_rdata;
    logic                r_rd_valid;
    logic                r_irq;
    logic                w_unused_addr;

    // Only the low 16 address bits are decoded.
    assign w_unused_addr = ^{wr_addr[31:16], rd_addr[31:16]};

    assign w_wr_dec = decode_addr(wr_addr[15:0], BASE_ADDR, NUM_REGS);
    assign w_rd_dec = decode_addr(rd_addr[15:0], BASE_ADDR, NUM_REGS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [1:0] G_MODE = REG_MODE[2*gi +: 2];

            assign w_wr_hit[gi] = wr_en && w_wr_dec.hit && (w_wr_dec.idx == 6'(gi));

            gpcfg_reg_slice #(
                .MODE      (G_MODE),
                .RESET_VAL (RESET_VAL[REG_W*gi +: REG_W])
            ) u_slice (
                .i_clk      (hclk),
                .i_rst_n    (hresetn),
                .i_wr_hit   (w_wr_hit[gi]),
                .i_byte_en  (byte_en),
                .i_wdata    (wdata),
                .i_hw_val   (hw_val[REG_W*gi +: REG_W]),
                .i_hw_set   (hw_set[REG_W*gi +: REG_W]),
                .o_q        (w_cfg[gi]),
                .o_wr_pulse (wr_pulse[gi])
            );

            assign cfg_regs[REG_W*gi +: REG_W] = w_cfg[gi];

            // Only sticky status bits contribute to the interrupt.
            assign w_irq_src[gi] = (G_MODE == MODE_W1C) &&
                                   (|(w_cfg[gi] & IRQ_MASK[REG_W*gi +: REG_W]));
        end
    endgenerate

    // Read mux on current state, so a colliding write is not visible to the read.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_dec.hit) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_rd_dec.idx == 6'(i)) begin
                    w_rd_word = w_cfg[i];
                end
            end
        end
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Registered interrupt reduction over masked sticky bits.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_irq_src;
        end
    end

    assign rdata    = r_rdata;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

endmodule
